// File: rtl/cdb_pkg.sv
// Shared types and helpers for the writeback/CDB arbitration slice.
// Tag and register widths are fixed here; the top-level parameters must match them.
package cdb_pkg;

   localparam int CDB_TAG_W  = 5;
   localparam int CDB_PREG_W = 7;

   localparam logic [1:0] SRC_ALU = 2'd0;
   localparam logic [1:0] SRC_BR  = 2'd1;
   localparam logic [1:0] SRC_MEM = 2'd2;

   typedef struct packed {
      logic                  valid;
      logic [CDB_TAG_W-1:0]  rob_tag;
      logic [CDB_PREG_W-1:0] pd;
      logic [31:0]           data;
      logic                  we;
      logic                  mispredict;
   } cdb_entry_t;

   // Distance from the ROB head decides age, so wrap-around of tags is harmless.
   function automatic logic rob_younger(input logic [CDB_TAG_W-1:0] tag,
                                        input logic [CDB_TAG_W-1:0] head,
                                        input logic [CDB_TAG_W-1:0] ref_tag);
      logic [CDB_TAG_W-1:0] tag_age;
      logic [CDB_TAG_W-1:0] ref_age;
      tag_age = tag - head;
      ref_age = ref_tag - head;
      return tag_age > ref_age;
   endfunction

endpackage

// File: rtl/cdb_arbiter_wb_queue.sv
// Per-source writeback queue: head at slot 0, shift-style pop, flush of entries
// younger than a mispredict with compaction, and an issue-side ready flag.
module wb_queue import cdb_pkg::*; #(
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  cdb_entry_t           push_entry,
   input  logic                 pop,
   input  logic                 flush,
   input  logic [CDB_TAG_W-1:0] flush_tag,
   input  logic [CDB_TAG_W-1:0] rob_head,
   output cdb_entry_t           head,
   output logic                 ready,
   output logic                 overflow
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

   cdb_entry_t       ent_q [DEPTH];
   cdb_entry_t       ent_d [DEPTH];
   cdb_entry_t       shifted [DEPTH];
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             accept;
   int               fill;

   // Pop, then drop flushed entries, then compact survivors and append the new result.
   always_comb begin
      for (int i = 0; i < DEPTH - 1; i++) begin
         shifted[i] = pop ? ent_q[i+1] : ent_q[i];
      end
      shifted[DEPTH-1] = pop ? '0 : ent_q[DEPTH-1];

      for (int i = 0; i < DEPTH; i++) begin
         if (flush && shifted[i].valid && rob_younger(shifted[i].rob_tag, rob_head, flush_tag)) begin
            shifted[i].valid = 1'b0;
         end else begin
            shifted[i].valid = shifted[i].valid;
         end
      end

      fill = 0;
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (shifted[i].valid && fill < DEPTH) begin
            ent_d[fill[IDX_W-1:0]] = shifted[i];
            fill = fill + 1;
         end else begin
            fill = fill;
         end
      end

      accept   = push && !(flush && rob_younger(push_entry.rob_tag, rob_head, flush_tag));
      overflow = 1'b0;
      if (accept && fill < DEPTH) begin
         ent_d[fill[IDX_W-1:0]]       = push_entry;
         ent_d[fill[IDX_W-1:0]].valid = 1'b1;
         fill = fill + 1;
      end else begin
         overflow = accept;
      end
      count_d = CNT_W'(fill);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
         count_q <= '0;
      end else begin
         ent_q   <= ent_d;
         count_q <= count_d;
      end
   end

   assign head  = ent_q[0];
   assign ready = (count_q <= READY_MAX);

endmodule

// File: rtl/cdb_arbiter.sv
// Writeback stage: three FU result queues arbitrated round-robin onto one
// registered common data bus, with mispredict squash and issue backpressure.
module cdb_arbiter import cdb_pkg::*; #(
   parameter int DEPTH  = 4,
   parameter int TAG_W  = CDB_TAG_W,
   parameter int PREG_W = CDB_PREG_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alu_valid,
   input  logic [TAG_W-1:0]  alu_rob_tag,
   input  logic [PREG_W-1:0] alu_pd,
   input  logic [31:0]       alu_data,
   input  logic              alu_we,
   input  logic              b_valid,
   input  logic [TAG_W-1:0]  b_rob_tag,
   input  logic [PREG_W-1:0] b_pd,
   input  logic [31:0]       b_data,
   input  logic              b_we,
   input  logic              b_mispredict,
   input  logic              mem_valid,
   input  logic [TAG_W-1:0]  mem_rob_tag,
   input  logic [PREG_W-1:0] mem_pd,
   input  logic [31:0]       mem_data,
   input  logic              mem_we,
   input  logic [TAG_W-1:0]  rob_head,
   input  logic              mispredict,
   input  logic [TAG_W-1:0]  mispredict_tag,
   output logic              alu_ready,
   output logic              b_ready,
   output logic              mem_ready,
   output logic              cdb_valid,
   output logic [TAG_W-1:0]  cdb_rob_tag,
   output logic [PREG_W-1:0] cdb_pd,
   output logic [31:0]       cdb_data,
   output logic              cdb_we,
   output logic              cdb_mispredict,
   output logic [1:0]        cdb_src,
   output logic              overflow_err
);

   cdb_entry_t in_entry [3];
   cdb_entry_t head [3];
   logic       push [3];
   logic       pop [3];
   logic       ready [3];
   logic       ovf [3];

   logic [1:0] order [3];
   logic       grant_valid;
   logic [1:0] grant_src;
   cdb_entry_t grant_entry;
   logic       squash;

   cdb_entry_t cdb_q, cdb_d;
   logic [1:0] src_q, src_d;
   logic [1:0] last_grant_q, last_grant_d;
   logic       overflow_q, overflow_d;

   assign push[0] = alu_valid;
   assign push[1] = b_valid;
   assign push[2] = mem_valid;

   // Pack each FU's result bus into a queue entry.
   always_comb begin
      in_entry[0] = '{valid: 1'b1, rob_tag: alu_rob_tag, pd: alu_pd, data: alu_data,
                      we: alu_we, mispredict: 1'b0};
      in_entry[1] = '{valid: 1'b1, rob_tag: b_rob_tag, pd: b_pd, data: b_data,
                      we: b_we, mispredict: b_mispredict};
      in_entry[2] = '{valid: 1'b1, rob_tag: mem_rob_tag, pd: mem_pd, data: mem_data,
                      we: mem_we, mispredict: 1'b0};
   end

   for (genvar g = 0; g < 3; g++) begin : g_q
      wb_queue #(.DEPTH(DEPTH)) u_q (
         .clk        (clk),
         .reset      (reset),
         .push       (push[g]),
         .push_entry (in_entry[g]),
         .pop        (pop[g]),
         .flush      (mispredict),
         .flush_tag  (mispredict_tag),
         .rob_head   (rob_head),
         .head       (head[g]),
         .ready      (ready[g]),
         .overflow   (ovf[g])
      );
      assign pop[g] = grant_valid && (grant_src == 2'(g));
   end

   // Round-robin: search starts at the source after the last grant.
   always_comb begin
      case (last_grant_q)
         SRC_ALU: begin order[0] = SRC_BR;  order[1] = SRC_MEM; order[2] = SRC_ALU; end
         SRC_BR:  begin order[0] = SRC_MEM; order[1] = SRC_ALU; order[2] = SRC_BR;  end
         default: begin order[0] = SRC_ALU; order[1] = SRC_BR;  order[2] = SRC_MEM; end
      endcase
      if (head[order[0]].valid) begin
         grant_valid = 1'b1;
         grant_src   = order[0];
      end else if (head[order[1]].valid) begin
         grant_valid = 1'b1;
         grant_src   = order[1];
      end else if (head[order[2]].valid) begin
         grant_valid = 1'b1;
         grant_src   = order[2];
      end else begin
         grant_valid = 1'b0;
         grant_src   = last_grant_q;
      end
      grant_entry = head[grant_src];
      squash      = mispredict && rob_younger(grant_entry.rob_tag, rob_head, mispredict_tag);
   end

   // A squashed grant still pops and advances the pointer, but is not broadcast.
   always_comb begin
      cdb_d        = cdb_q;
      cdb_d.valid  = 1'b0;
      src_d        = src_q;
      last_grant_d = last_grant_q;
      if (grant_valid) begin
         last_grant_d = grant_src;
         if (!squash) begin
            cdb_d = grant_entry;
            src_d = grant_src;
         end else begin
            cdb_d.valid = 1'b0;
         end
      end else begin
         last_grant_d = last_grant_q;
      end
      overflow_d = overflow_q | ovf[0] | ovf[1] | ovf[2];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cdb_q        <= '0;
         src_q        <= SRC_ALU;
         last_grant_q <= SRC_MEM;
         overflow_q   <= 1'b0;
      end else begin
         cdb_q        <= cdb_d;
         src_q        <= src_d;
         last_grant_q <= last_grant_d;
         overflow_q   <= overflow_d;
      end
   end

   assign alu_ready      = ready[0];
   assign b_ready        = ready[1];
   assign mem_ready      = ready[2];
   assign cdb_valid      = cdb_q.valid;
   assign cdb_rob_tag    = cdb_q.rob_tag;
   assign cdb_pd         = cdb_q.pd;
   assign cdb_data       = cdb_q.data;
   assign cdb_we         = cdb_q.we;
   assign cdb_mispredict = cdb_q.mispredict;
   assign cdb_src        = src_q;
   assign overflow_err   = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: latency, RR order, backpressure/overflow,
// wrap-around flush, same-cycle squash and asynchronous reset.
module tb_cdb_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        alu_valid = 1'b0, b_valid = 1'b0, mem_valid = 1'b0;
   logic [4:0]  alu_rob_tag = 5'd0, b_rob_tag = 5'd0, mem_rob_tag = 5'd0;
   logic [6:0]  alu_pd = 7'd0, b_pd = 7'd0, mem_pd = 7'd0;
   logic [31:0] alu_data = 32'd0, b_data = 32'd0, mem_data = 32'd0;
   logic        alu_we = 1'b0, b_we = 1'b0, mem_we = 1'b0;
   logic        b_mispredict = 1'b0;
   logic [4:0]  rob_head = 5'd0;
   logic        mispredict = 1'b0;
   logic [4:0]  mispredict_tag = 5'd0;
   logic        alu_ready, b_ready, mem_ready;
   logic        cdb_valid, cdb_we, cdb_mispredict, overflow_err;
   logic [4:0]  cdb_rob_tag;
   logic [6:0]  cdb_pd;
   logic [31:0] cdb_data;
   logic [1:0]  cdb_src;

   int pass_cnt = 0;
   int total_cnt = 0;

   cdb_arbiter dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_rob_tag(alu_rob_tag), .alu_pd(alu_pd),
      .alu_data(alu_data), .alu_we(alu_we),
      .b_valid(b_valid), .b_rob_tag(b_rob_tag), .b_pd(b_pd), .b_data(b_data),
      .b_we(b_we), .b_mispredict(b_mispredict),
      .mem_valid(mem_valid), .mem_rob_tag(mem_rob_tag), .mem_pd(mem_pd),
      .mem_data(mem_data), .mem_we(mem_we),
      .rob_head(rob_head), .mispredict(mispredict), .mispredict_tag(mispredict_tag),
      .alu_ready(alu_ready), .b_ready(b_ready), .mem_ready(mem_ready),
      .cdb_valid(cdb_valid), .cdb_rob_tag(cdb_rob_tag), .cdb_pd(cdb_pd),
      .cdb_data(cdb_data), .cdb_we(cdb_we), .cdb_mispredict(cdb_mispredict),
      .cdb_src(cdb_src), .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 1'b0;
      b_valid = 1'b0;
      mem_valid = 1'b0;
      b_mispredict = 1'b0;
   endtask

   // Source s presents a result; pd/data derive from the tag so they can be checked.
   task automatic set_fu(input int s, input logic [4:0] tag, input logic mp);
      logic [6:0]  pd;
      logic [31:0] data;
      pd   = {2'b00, tag} + 7'd1;
      data = {27'd0, tag} ^ 32'hC0DE_0000;
      case (s)
         0: begin alu_valid = 1'b1; alu_rob_tag = tag; alu_pd = pd; alu_data = data; alu_we = 1'b1; end
         1: begin b_valid = 1'b1; b_rob_tag = tag; b_pd = pd; b_data = data; b_we = 1'b1; b_mispredict = mp; end
         default: begin mem_valid = 1'b1; mem_rob_tag = tag; mem_pd = pd; mem_data = data; mem_we = 1'b1; end
      endcase
   endtask

   task automatic expect_bc(input string name, input logic [4:0] tag, input logic [1:0] src);
      chk({name, "_valid"}, {31'd0, cdb_valid}, 32'd1);
      chk({name, "_tag"}, {27'd0, cdb_rob_tag}, {27'd0, tag});
      chk({name, "_src"}, {30'd0, cdb_src}, {30'd0, src});
   endtask

   task automatic expect_idle(input string name);
      chk({name, "_valid"}, {31'd0, cdb_valid}, 32'd0);
   endtask

   task automatic do_reset();
      idle();
      mispredict = 1'b0;
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("rst_valid", {31'd0, cdb_valid}, 32'd0);
      chk("rst_data", cdb_data, 32'd0);
      chk("rst_tag", {27'd0, cdb_rob_tag}, 32'd0);
      chk("rst_ovf", {31'd0, overflow_err}, 32'd0);
      chk("rst_ready", {29'd0, alu_ready, b_ready, mem_ready}, 32'd7);

      // Single ALU result: t+2 latency, one pulse, fields intact
      alu_valid = 1'b1; alu_rob_tag = 5'd3; alu_pd = 7'd10; alu_data = 32'hDEAD_BEEF; alu_we = 1'b1;
      tick();
      idle();
      expect_idle("single_t1");
      tick();
      expect_bc("single_t2", 5'd3, 2'd0);
      chk("single_pd", {25'd0, cdb_pd}, 32'd10);
      chk("single_data", cdb_data, 32'hDEAD_BEEF);
      chk("single_we", {31'd0, cdb_we}, 32'd1);
      chk("single_mp", {31'd0, cdb_mispredict}, 32'd0);
      tick();
      expect_idle("single_t3");
      chk("single_hold", cdb_data, 32'hDEAD_BEEF);

      // Two simultaneous bursts: RR order ALU, BR, MEM twice
      do_reset();
      set_fu(0, 5'd1, 1'b0); set_fu(1, 5'd2, 1'b0); set_fu(2, 5'd3, 1'b0);
      tick();
      set_fu(0, 5'd4, 1'b0); set_fu(1, 5'd5, 1'b0); set_fu(2, 5'd6, 1'b0);
      tick();
      idle();
      expect_bc("burst_1", 5'd1, 2'd0);
      chk("burst_1_pd", {25'd0, cdb_pd}, 32'd2);
      tick(); expect_bc("burst_2", 5'd2, 2'd1);
      tick(); expect_bc("burst_3", 5'd3, 2'd2);
      chk("burst_3_data", cdb_data, 32'hC0DE_0003);
      tick(); expect_bc("burst_4", 5'd4, 2'd0);
      tick(); expect_bc("burst_5", 5'd5, 2'd1);
      tick(); expect_bc("burst_6", 5'd6, 2'd2);
      tick(); expect_idle("burst_end");

      // Wrap-around flush: head 30, tags 31/0/2, mispredict at 0 kills tag 2
      do_reset();
      rob_head = 5'd30;
      set_fu(0, 5'd31, 1'b0); set_fu(1, 5'd0, 1'b1); set_fu(2, 5'd2, 1'b0);
      tick();
      idle();
      mispredict = 1'b1; mispredict_tag = 5'd0;
      tick();
      mispredict = 1'b0;
      expect_bc("wrap_31", 5'd31, 2'd0);
      tick();
      expect_bc("wrap_0", 5'd0, 2'd1);
      chk("wrap_0_mp", {31'd0, cdb_mispredict}, 32'd1);
      tick(); expect_idle("wrap_no2_a");
      tick(); expect_idle("wrap_no2_b");

      // Same-cycle squash of granted younger head and incoming younger result
      do_reset();
      rob_head = 5'd0;
      set_fu(0, 5'd9, 1'b0); set_fu(1, 5'd5, 1'b1);
      tick();
      idle();
      mispredict = 1'b1; mispredict_tag = 5'd5;
      set_fu(0, 5'd7, 1'b0);
      tick();
      idle();
      mispredict = 1'b0;
      expect_idle("squash_grant");
      tick();
      expect_bc("squash_branch", 5'd5, 2'd1);
      chk("squash_branch_mp", {31'd0, cdb_mispredict}, 32'd1);
      tick(); expect_idle("squash_none_a");
      tick(); expect_idle("squash_none_b");

      // MEM backpressure and overflow while ALU/BR share the bus
      do_reset();
      set_fu(0, 5'd1, 1'b0); set_fu(1, 5'd3, 1'b0); set_fu(2, 5'd10, 1'b0);
      tick();
      expect_idle("ovf_e0");
      chk("ovf_ready_c1", {31'd0, mem_ready}, 32'd1);
      set_fu(0, 5'd2, 1'b0); set_fu(1, 5'd4, 1'b0); set_fu(2, 5'd11, 1'b0);
      tick();
      idle();
      expect_bc("ovf_e1", 5'd1, 2'd0);
      chk("ovf_ready_c2", {31'd0, mem_ready}, 32'd1);
      set_fu(2, 5'd12, 1'b0);
      tick();
      expect_bc("ovf_e2", 5'd3, 2'd1);
      chk("ovf_ready_c3", {31'd0, mem_ready}, 32'd0);
      chk("ovf_alu_ready", {31'd0, alu_ready}, 32'd1);
      set_fu(2, 5'd13, 1'b0);
      tick();
      expect_bc("ovf_e3", 5'd10, 2'd2);
      set_fu(2, 5'd14, 1'b0);
      tick();
      expect_bc("ovf_e4", 5'd2, 2'd0);
      chk("ovf_flag_before", {31'd0, overflow_err}, 32'd0);
      set_fu(2, 5'd15, 1'b0);
      tick();
      idle();
      expect_bc("ovf_e5", 5'd4, 2'd1);
      chk("ovf_flag_set", {31'd0, overflow_err}, 32'd1);
      tick(); expect_bc("ovf_e6", 5'd11, 2'd2);
      tick(); expect_bc("ovf_e7", 5'd12, 2'd2);
      chk("ovf_ready_back", {31'd0, mem_ready}, 32'd1);
      tick(); expect_bc("ovf_e8", 5'd13, 2'd2);
      tick(); expect_bc("ovf_e9", 5'd14, 2'd2);
      tick(); expect_idle("ovf_dropped");
      chk("ovf_sticky", {31'd0, overflow_err}, 32'd1);

      // Asynchronous reset with three entries queued
      set_fu(0, 5'd20, 1'b0); set_fu(1, 5'd21, 1'b0); set_fu(2, 5'd22, 1'b0);
      tick();
      idle();
      set_fu(0, 5'd23, 1'b0);
      tick();
      idle();
      expect_bc("arst_pre", 5'd20, 2'd0);
      #2 reset = 1'b0;
      #1;
      chk("arst_valid", {31'd0, cdb_valid}, 32'd0);
      chk("arst_tag", {27'd0, cdb_rob_tag}, 32'd0);
      chk("arst_ovf", {31'd0, overflow_err}, 32'd0);
      chk("arst_ready", {29'd0, alu_ready, b_ready, mem_ready}, 32'd7);
      tick();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         expect_idle("arst_stale");
      end
      chk("arst_ready_after", {29'd0, alu_ready, b_ready, mem_ready}, 32'd7);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
